// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, PC, stall/branch/halt control.
// Optional perf counters (outFetchCnt, outStallCnt) are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter int ADDR_W = 32,
  parameter int INSN_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INSN_W-1:0] NOP_INSN = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] outInsnAddr,
  input  logic [INSN_W-1:0] inInsn,
  input  logic              inStall,
  input  logic              inBrTaken,
  input  logic [ADDR_W-1:0] inBrTarget,
  input  logic              inHalt,
  output logic [INSN_W-1:0] outInsn,
  output logic [ADDR_W-1:0] outIncrementedInsn,
  output logic              outValid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       outFetchCnt,
  output logic [31:0]       outStallCnt,
`endif
  output logic              outHalted
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} fetchState_t;

  fetchState_t       stateReg, stateNext;
  logic [ADDR_W-1:0] pcReg, pcNext;
  logic [INSN_W-1:0] insnReg, insnNext;
  logic [ADDR_W-1:0] incReg, incNext;
  logic              validReg, validNext;
  logic [ADDR_W-1:0] pcPlusOne;
  logic              fetchEvent;
  logic              stallEvent;

  // Wraps naturally at 2^ADDR_W.
  assign pcPlusOne = pcReg + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg <= RUN;
      pcReg    <= RESET_PC;
      insnReg  <= NOP_INSN;
      incReg   <= '0;
      validReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      pcReg    <= pcNext;
      insnReg  <= insnNext;
      incReg   <= incNext;
      validReg <= validNext;
    end
  end

  always_comb begin
    stateNext  = stateReg;
    pcNext     = pcReg;
    insnNext   = insnReg;
    incNext    = incReg;
    validNext  = validReg;
    fetchEvent = 1'b0;
    stallEvent = 1'b0;
    case (stateReg)
      RUN: begin
        if (inBrTaken) begin
          pcNext    = inBrTarget;
          insnNext  = NOP_INSN;
          incNext   = '0;
          validNext = 1'b0;
        end else if (inHalt) begin
          insnNext  = NOP_INSN;
          incNext   = '0;
          validNext = 1'b0;
          stateNext = HALTED;
        end else if (inStall) begin
          stallEvent = 1'b1;
        end else begin
          pcNext     = pcPlusOne;
          insnNext   = inInsn;
          incNext    = pcPlusOne;
          validNext  = 1'b1;
          fetchEvent = 1'b1;
        end
      end
      HALTED: begin
        // Only a redirect leaves HALTED; stall and halt are ignored here.
        insnNext  = NOP_INSN;
        incNext   = '0;
        validNext = 1'b0;
        if (inBrTaken) begin
          pcNext    = inBrTarget;
          stateNext = RUN;
        end
      end
      default: begin
        stateNext = RUN;
      end
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCntReg;
  logic [31:0] stallCntReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchCntReg <= '0;
      stallCntReg <= '0;
    end else begin
      if (fetchEvent) fetchCntReg <= fetchCntReg + 32'd1;
      if (stallEvent) stallCntReg <= stallCntReg + 32'd1;
    end
  end

  assign outFetchCnt = fetchCntReg;
  assign outStallCnt = stallCntReg;
`else
  logic unusedEvents;
  assign unusedEvents = fetchEvent ^ stallEvent;
`endif

  assign outInsnAddr        = pcReg;
  assign outInsn            = insnReg;
  assign outIncrementedInsn = incReg;
  assign outValid           = validReg;
  assign outHalted          = (stateReg == HALTED);

endmodule
